// File: rtl/gbt_xu5_link_pkg.sv
// Shared definitions for the XU5 GBT-style link: frame geometry, header,
// aligner state encoding and the frame check function.
package gbt_xu5_link_pkg;

  localparam int GBT_FRAME_W = 120;
  localparam int GBT_DATA_W  = 84;
  localparam logic [3:0] GBT_HEADER = 4'b0101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } gbt_state_t;

  function automatic logic [31:0] gbt_chk(input logic [GBT_DATA_W-1:0] d);
    return d[83:52] ^ d[51:20] ^ {d[19:0], 12'h000};
  endfunction

endpackage

// File: rtl/gbt_xu5_rx_aligner.sv
// Receive path: registers the transceiver word, rotates it by the current slip,
// hunts for header+check alignment, then delivers payloads while locked.
module gbt_xu5_rx_aligner
  import gbt_xu5_link_pkg::*;
#(
  parameter int LOCK_FRAMES   = 16,
  parameter int UNLOCK_ERRORS = 4,
  parameter int SLIP_WAIT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   los,
  input  logic                   bitslip_reset,
  input  logic [GBT_FRAME_W-1:0] rx_frame,
  output logic [GBT_DATA_W-1:0]  data_received,
  output logic                   rx_valid,
  output logic                   link_ready,
  output logic [15:0]            rx_error_cnt,
  output logic [6:0]             slip,
  output gbt_state_t             state
);

  localparam logic [15:0] LOCK_N   = 16'(LOCK_FRAMES);
  localparam logic [15:0] UNLOCK_N = 16'(UNLOCK_ERRORS);
  localparam logic [7:0]  WAIT_N   = 8'(SLIP_WAIT);
  localparam logic [6:0]  SLIP_MAX = 7'd119;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [6:0] slip_inc(input logic [6:0] s);
    return (s == SLIP_MAX) ? 7'd0 : s + 7'd1;
  endfunction

  function automatic logic [GBT_FRAME_W-1:0] rotl(input logic [GBT_FRAME_W-1:0] f,
                                                  input logic [6:0] s);
    logic [2*GBT_FRAME_W-1:0] dbl;
    dbl = {f, f} << s;
    return dbl[2*GBT_FRAME_W-1:GBT_FRAME_W];
  endfunction

  logic [GBT_FRAME_W-1:0] rx_q_p1;
  logic [GBT_FRAME_W-1:0] aligned_p2;
  logic                   good_p2;

  logic [7:0]  wait_cnt, wait_nx;
  logic [15:0] good_cnt, good_nx;
  logic [15:0] bad_cnt, bad_nx;
  logic [15:0] err_nx;
  logic [6:0]  slip_nx;
  logic [GBT_DATA_W-1:0] data_nx;
  logic        vld_nx, ready_nx;
  gbt_state_t  state_nx;

  // Stage 1: capture raw transceiver word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_q_p1 <= '0;
    else     rx_q_p1 <= rx_frame;
  end

  // Stage 2: rotate by current slip and qualify the frame
  assign aligned_p2 = rotl(rx_q_p1, slip);
  assign good_p2    = (aligned_p2[119:116] == GBT_HEADER) &&
                      (aligned_p2[31:0] == gbt_chk(aligned_p2[115:32]));

  always_comb begin
    state_nx = state;
    slip_nx  = slip;
    wait_nx  = wait_cnt;
    good_nx  = good_cnt;
    bad_nx   = bad_cnt;
    err_nx   = rx_error_cnt;
    data_nx  = data_received;
    vld_nx   = 1'b0;
    ready_nx = link_ready;
    // Loss of light or a slip restart overrides every state.
    if (los || bitslip_reset) begin
      state_nx = ST_IDLE;
      slip_nx  = '0;
      wait_nx  = '0;
      good_nx  = '0;
      bad_nx   = '0;
      err_nx   = '0;
      ready_nx = 1'b0;
    end else begin
      case (state)
        ST_IDLE: state_nx = ST_SEARCH;
        ST_SEARCH: begin
          if (wait_cnt != 8'd0) begin
            wait_nx = wait_cnt - 8'd1;
          end else if (good_p2) begin
            good_nx = 16'd1;
            if (LOCK_N <= 16'd1) begin
              state_nx = ST_LOCKED;
              ready_nx = 1'b1;
              bad_nx   = '0;
            end else begin
              state_nx = ST_VERIFY;
            end
          end else begin
            slip_nx = slip_inc(slip);
            wait_nx = WAIT_N;
          end
        end
        ST_VERIFY: begin
          if (good_p2) begin
            good_nx = good_cnt + 16'd1;
            if (good_cnt + 16'd1 >= LOCK_N) begin
              state_nx = ST_LOCKED;
              ready_nx = 1'b1;
              bad_nx   = '0;
            end
          end else begin
            state_nx = ST_SEARCH;
            slip_nx  = slip_inc(slip);
            wait_nx  = WAIT_N;
            good_nx  = '0;
          end
        end
        ST_LOCKED: begin
          if (good_p2) begin
            data_nx = aligned_p2[115:32];
            vld_nx  = 1'b1;
            bad_nx  = '0;
          end else begin
            bad_nx = bad_cnt + 16'd1;
            err_nx = sat_inc16(rx_error_cnt);
            if (bad_cnt + 16'd1 >= UNLOCK_N) begin
              state_nx = ST_SEARCH;
              ready_nx = 1'b0;
              bad_nx   = '0;
              good_nx  = '0;
              wait_nx  = '0;
            end
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Stage 3: aligner state, counters and delivered payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      slip          <= '0;
      wait_cnt      <= '0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      rx_error_cnt  <= '0;
      data_received <= '0;
      rx_valid      <= 1'b0;
      link_ready    <= 1'b0;
    end else begin
      state         <= state_nx;
      slip          <= slip_nx;
      wait_cnt      <= wait_nx;
      good_cnt      <= good_nx;
      bad_cnt       <= bad_nx;
      rx_error_cnt  <= err_nx;
      data_received <= data_nx;
      rx_valid      <= vld_nx;
      link_ready    <= ready_nx;
    end
  end

endmodule

// File: rtl/gbt_xu5_link.sv
// GBT-style link layer for the XU5 SFP1 channel: inline TX frame encoder plus
// the receive aligner; debug observability gated by DEBUG.
module gbt_xu5_link
  import gbt_xu5_link_pkg::*;
#(
  parameter int DEBUG         = 0,
  parameter int LOCK_FRAMES   = 16,
  parameter int UNLOCK_ERRORS = 4,
  parameter int SLIP_WAIT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sfp1_los_i,
  input  logic                   bitslip_reset_i,
  input  logic [GBT_DATA_W-1:0]  data_sent_i,
  output logic [GBT_FRAME_W-1:0] tx_frame_o,
  input  logic [GBT_FRAME_W-1:0] rx_frame_i,
  output logic [GBT_DATA_W-1:0]  data_received_o,
  output logic                   rx_valid_o,
  output logic                   link_ready_o,
  output logic [15:0]            rx_error_cnt_o,
  output logic [6:0]             rx_bitslip_o,
  output logic [1:0]             state_o
);

  logic [GBT_FRAME_W-1:0] tx_frame_p1;
  logic [6:0]             slip;
  gbt_state_t             state;

  // Stage 1: TX frame register; runs regardless of LOS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_frame_p1 <= '0;
    else     tx_frame_p1 <= {GBT_HEADER, data_sent_i, gbt_chk(data_sent_i)};
  end

  assign tx_frame_o = tx_frame_p1;

  gbt_xu5_rx_aligner #(
    .LOCK_FRAMES  (LOCK_FRAMES),
    .UNLOCK_ERRORS(UNLOCK_ERRORS),
    .SLIP_WAIT    (SLIP_WAIT)
  ) u_rx_aligner (
    .clk          (clk),
    .rst          (rst),
    .los          (sfp1_los_i),
    .bitslip_reset(bitslip_reset_i),
    .rx_frame     (rx_frame_i),
    .data_received(data_received_o),
    .rx_valid     (rx_valid_o),
    .link_ready   (link_ready_o),
    .rx_error_cnt (rx_error_cnt_o),
    .slip         (slip),
    .state        (state)
  );

  assign rx_bitslip_o = (DEBUG != 0) ? slip : 7'd0;
  assign state_o      = (DEBUG != 0) ? 2'(state) : 2'd0;

endmodule

// File: tb/tb_gbt_xu5_link.sv
// Directed bench for gbt_xu5_link: transceiver modelled as a loopback with
// optional right-rotation and check-bit corruption.
`timescale 1ns/1ps
module tb_gbt_xu5_link;

  localparam logic [83:0]  DATA_A  = 84'h000bebeac1dacdcfffff;
  localparam logic [119:0] FRAME_A = 120'h5_0000bebeac1dacdcfffff_53e2e262;
  localparam logic [83:0]  DATA_B  = 84'h123456789abcdef012345;
  localparam logic [119:0] FRAME_B = 120'h5_123456789abcdef012345_9abcd888;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sfp1_los_i = 1'b1;
  logic         bitslip_reset_i = 1'b0;
  logic [83:0]  data_sent_i = DATA_A;
  logic [119:0] tx_frame_o;
  logic [119:0] rx_frame_i;
  logic [83:0]  data_received_o;
  logic         rx_valid_o;
  logic         link_ready_o;
  logic [15:0]  rx_error_cnt_o;
  logic [6:0]   rx_bitslip_o;
  logic [1:0]   state_o;

  logic [6:0]   rot = 7'd0;
  logic         corrupt = 1'b0;
  int tests = 0;
  int fails = 0;

  always #12.5 clk = ~clk;

  function automatic logic [119:0] rotr(input logic [119:0] x, input logic [6:0] r);
    logic [239:0] dbl;
    dbl = {x, x} >> r;
    return dbl[119:0];
  endfunction

  always_comb rx_frame_i = rotr(tx_frame_o ^ (corrupt ? 120'h1 : 120'h0), rot);

  gbt_xu5_link #(.DEBUG(1), .LOCK_FRAMES(16), .UNLOCK_ERRORS(4), .SLIP_WAIT(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .sfp1_los_i     (sfp1_los_i),
    .bitslip_reset_i(bitslip_reset_i),
    .data_sent_i    (data_sent_i),
    .tx_frame_o     (tx_frame_o),
    .rx_frame_i     (rx_frame_i),
    .data_received_o(data_received_o),
    .rx_valid_o     (rx_valid_o),
    .link_ready_o   (link_ready_o),
    .rx_error_cnt_o (rx_error_cnt_o),
    .rx_bitslip_o   (rx_bitslip_o),
    .state_o        (state_o)
  );

  task automatic test_reset;
    #2;
    tests++; if (tx_frame_o !== 120'h0) begin fails++; $display("FAIL reset_tx got %h want 0", tx_frame_o); end
    tests++; if (data_received_o !== 84'h0) begin fails++; $display("FAIL reset_data got %h want 0", data_received_o); end
    tests++; if ({rx_valid_o, link_ready_o} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {rx_valid_o, link_ready_o}); end
    tests++; if (rx_error_cnt_o !== 16'h0) begin fails++; $display("FAIL reset_err got %h want 0", rx_error_cnt_o); end
    tests++; if ({rx_bitslip_o, state_o} !== 9'h0) begin fails++; $display("FAIL reset_slip_state got %h want 0", {rx_bitslip_o, state_o}); end
  endtask

  task automatic test_loopback;
    int n;
    @(negedge clk); rst = 1'b0;
    repeat (398) @(negedge clk);
    tests++; if (tx_frame_o !== FRAME_A) begin fails++; $display("FAIL tx_encode got %h want %h", tx_frame_o, FRAME_A); end
    tests++; if ({link_ready_o, state_o} !== 3'b000) begin fails++; $display("FAIL los_idle got %b want 000", {link_ready_o, state_o}); end
    sfp1_los_i = 1'b0;
    n = 0;
    while (link_ready_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests++; if (link_ready_o !== 1'b1) begin fails++; $display("FAIL lock0_timeout got %b want 1", link_ready_o); end
    tests++; if (n < 16 || n > 20) begin fails++; $display("FAIL lock0_latency got %0d want 16..20", n); end
    tests++; if (rx_bitslip_o !== 7'd0) begin fails++; $display("FAIL lock0_slip got %0d want 0", rx_bitslip_o); end
    repeat (2) @(negedge clk);
    tests++; if (data_received_o !== DATA_A) begin fails++; $display("FAIL lock0_data got %h want %h", data_received_o, DATA_A); end
    tests++; if (rx_valid_o !== 1'b1) begin fails++; $display("FAIL lock0_valid got %b want 1", rx_valid_o); end
    tests++; if (state_o !== 2'd3) begin fails++; $display("FAIL lock0_state got %0d want 3", state_o); end
  endtask

  task automatic test_rotated;
    int n;
    rot = 7'd37; bitslip_reset_i = 1'b1;
    repeat (3) @(negedge clk);
    bitslip_reset_i = 1'b0;
    n = 0;
    while (link_ready_o !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    tests++; if (link_ready_o !== 1'b1) begin fails++; $display("FAIL lock37_timeout got %b want 1", link_ready_o); end
    tests++; if (rx_bitslip_o !== 7'd37) begin fails++; $display("FAIL lock37_slip got %0d want 37", rx_bitslip_o); end
    tests++; if (rx_error_cnt_o !== 16'd0) begin fails++; $display("FAIL lock37_err got %0d want 0", rx_error_cnt_o); end
    repeat (2) @(negedge clk);
    tests++; if (data_received_o !== DATA_A) begin fails++; $display("FAIL lock37_data got %h want %h", data_received_o, DATA_A); end
  endtask

  task automatic test_errors;
    int n;
    corrupt = 1'b1;
    @(negedge clk); @(negedge clk);
    tests++; if (rx_valid_o !== 1'b0) begin fails++; $display("FAIL bad_valid got %b want 0", rx_valid_o); end
    @(negedge clk); corrupt = 1'b0;
    repeat (4) @(negedge clk);
    tests++; if (link_ready_o !== 1'b1) begin fails++; $display("FAIL err3_ready got %b want 1", link_ready_o); end
    tests++; if (rx_error_cnt_o !== 16'd3) begin fails++; $display("FAIL err3_cnt got %0d want 3", rx_error_cnt_o); end
    tests++; if (data_received_o !== DATA_A) begin fails++; $display("FAIL err3_data got %h want %h", data_received_o, DATA_A); end
    corrupt = 1'b1;
    repeat (4) @(negedge clk);
    corrupt = 1'b0;
    tests++; if (link_ready_o !== 1'b1) begin fails++; $display("FAIL err4_early_drop got %b want 1", link_ready_o); end
    @(negedge clk);
    tests++; if (link_ready_o !== 1'b0) begin fails++; $display("FAIL err4_drop got %b want 0", link_ready_o); end
    tests++; if (rx_error_cnt_o !== 16'd7) begin fails++; $display("FAIL err4_cnt got %0d want 7", rx_error_cnt_o); end
    n = 0;
    while (link_ready_o !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    tests++; if (link_ready_o !== 1'b1) begin fails++; $display("FAIL err4_relock got %b want 1", link_ready_o); end
    tests++; if (rx_bitslip_o !== 7'd37) begin fails++; $display("FAIL err4_slip got %0d want 37", rx_bitslip_o); end
  endtask

  task automatic test_los;
    int n;
    sfp1_los_i = 1'b1;
    @(negedge clk);
    tests++; if (link_ready_o !== 1'b0) begin fails++; $display("FAIL los_drop got %b want 0", link_ready_o); end
    tests++; if ({rx_bitslip_o, state_o} !== 9'h0) begin fails++; $display("FAIL los_slip_state got %h want 0", {rx_bitslip_o, state_o}); end
    repeat (5) @(negedge clk);
    tests++; if (data_received_o !== DATA_A) begin fails++; $display("FAIL los_hold got %h want %h", data_received_o, DATA_A); end
    sfp1_los_i = 1'b0;
    n = 0;
    while (link_ready_o !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    tests++; if (link_ready_o !== 1'b1) begin fails++; $display("FAIL los_relock got %b want 1", link_ready_o); end
    tests++; if (rx_bitslip_o !== 7'd37) begin fails++; $display("FAIL los_slip got %0d want 37", rx_bitslip_o); end
  endtask

  task automatic test_bitslip_reset;
    int n;
    bitslip_reset_i = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if ({link_ready_o, state_o} !== 3'b000) begin fails++; $display("FAIL bsr_idle got %b want 000", {link_ready_o, state_o}); end
    bitslip_reset_i = 1'b0;
    @(negedge clk);
    tests++; if ({rx_bitslip_o, state_o} !== {7'd0, 2'd1}) begin fails++; $display("FAIL bsr_restart got %h want %h", {rx_bitslip_o, state_o}, {7'd0, 2'd1}); end
    @(negedge clk);
    tests++; if (rx_bitslip_o !== 7'd1) begin fails++; $display("FAIL bsr_first_slip got %0d want 1", rx_bitslip_o); end
    n = 0;
    while (link_ready_o !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    tests++; if (link_ready_o !== 1'b1 || rx_bitslip_o !== 7'd37) begin fails++; $display("FAIL bsr_relock got %b/%0d want 1/37", link_ready_o, rx_bitslip_o); end
  endtask

  task automatic test_reset_mid_lock;
    int n;
    @(negedge clk); #3; rst = 1'b1; #1;
    tests++; if ({link_ready_o, rx_valid_o} !== 2'b00) begin fails++; $display("FAIL arst_flags got %b want 00", {link_ready_o, rx_valid_o}); end
    tests++; if (data_received_o !== 84'h0 || tx_frame_o !== 120'h0) begin fails++; $display("FAIL arst_data got %h/%h want 0", data_received_o, tx_frame_o); end
    tests++; if ({rx_error_cnt_o, rx_bitslip_o, state_o} !== 25'h0) begin fails++; $display("FAIL arst_cnt got %h want 0", {rx_error_cnt_o, rx_bitslip_o, state_o}); end
    data_sent_i = DATA_B; rot = 7'd0;
    @(negedge clk); rst = 1'b0;
    n = 0;
    while (link_ready_o !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    tests++; if (link_ready_o !== 1'b1) begin fails++; $display("FAIL arst_relock got %b want 1", link_ready_o); end
    tests++; if (rx_bitslip_o !== 7'd0) begin fails++; $display("FAIL arst_slip got %0d want 0", rx_bitslip_o); end
    repeat (2) @(negedge clk);
    tests++; if (tx_frame_o !== FRAME_B) begin fails++; $display("FAIL arst_tx got %h want %h", tx_frame_o, FRAME_B); end
    tests++; if (data_received_o !== DATA_B) begin fails++; $display("FAIL arst_data_new got %h want %h", data_received_o, DATA_B); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_rotated();
    test_errors();
    test_los();
    test_bitslip_reset();
    test_reset_mid_lock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
